// File: rtl/sat_dsp_pkg.sv
// Shared types and constants for the satellite DSP receive chain.
// Holds the demodulator FSM states, QPSK bit mapping and accumulator sizing.
package sat_dsp_pkg;

  typedef enum logic {
    SEARCH  = 1'b0,
    PAYLOAD = 1'b1
  } demod_state_t;

  localparam logic QPSK_POS_BIT = 1'b0;
  localparam logic QPSK_NEG_BIT = 1'b1;
  localparam int   SAMPLE_W     = 16;

  // Integrating SPS samples grows the sum by clog2(SPS) bits; one more keeps the sign safe.
  function automatic int acc_width(input int sps);
    return SAMPLE_W + $clog2(sps) + 1;
  endfunction

endpackage

// File: rtl/qpsk_symbol_fifo.sv
// Two-entry first-word-fall-through buffer for {dibit, last} output symbols.
// A push into a full buffer is ignored unless a pop frees a slot in the same cycle.
module qpsk_symbol_fifo
  import sat_dsp_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  logic [2:0] push_data_i,
  input  logic       pop_i,
  output logic [2:0] pop_data_o,
  output logic       full_o,
  output logic       empty_o
);

  logic [2:0] mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       do_push;
  logic       do_pop;

  assign full_o     = (count_q == 2'd2);
  assign empty_o    = (count_q == 2'd0);
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);
  assign pop_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q[0] <= 3'd0;
      mem_q[1] <= 3'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/qpsk_demodulator.sv
// QPSK receiver back end: integrate-and-dump per symbol, hard dibit decisions,
// preamble hunt with coarse timing slips, then a fixed-length payload stream out.
module qpsk_demodulator
  import sat_dsp_pkg::*;
#(
  parameter int                      SPS          = 4,
  parameter int                      PRE_SYMS     = 8,
  parameter logic [2*PRE_SYMS-1:0]   PREAMBLE     = 16'hE4E4,
  parameter int                      PAYLOAD_SYMS = 64,
  parameter int                      SEARCH_TO    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic signed [15:0] i_in,
  input  logic signed [15:0] q_in,
  output logic               sym_valid,
  input  logic               sym_ready,
  output logic [1:0]         sym_data,
  output logic               sym_last,
  output logic               locked,
  output logic               overflow
);

  localparam int ACC_W  = acc_width(SPS);
  localparam int PH_W   = $clog2(SPS);
  localparam int HIST_W = 2 * PRE_SYMS;
  localparam int SC_W   = $clog2(SEARCH_TO + 1);
  localparam int PC_W   = $clog2(PAYLOAD_SYMS + 1);

  logic signed [ACC_W-1:0] acc_i_q, acc_q_q;
  logic signed [ACC_W-1:0] sum_i_d, sum_q_d;
  logic [PH_W-1:0]         phase_q;
  logic                    slip_q;
  logic                    dec_v_q;
  logic [1:0]              dec_dibit_q;

  demod_state_t            state_q;
  logic [HIST_W-3:0]       hist_q;
  logic [HIST_W-1:0]       hist_d;
  logic [SC_W-1:0]         search_cnt_q;
  logic [PC_W-1:0]         pay_cnt_q;
  logic                    overflow_q;

  logic                    pay_last;
  logic                    slip_set;
  logic                    push;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [2:0]              fifo_dout;

  assign sum_i_d = acc_i_q + $signed({{(ACC_W-16){i_in[15]}}, i_in});
  assign sum_q_d = acc_q_q + $signed({{(ACC_W-16){q_in[15]}}, q_in});

  // Only the newest HIST_W-2 bits need storing; the incoming dibit completes the window.
  assign hist_d   = {hist_q, dec_dibit_q};
  assign pay_last = (pay_cnt_q == PC_W'(PAYLOAD_SYMS - 1));
  assign slip_set = dec_v_q && (state_q == SEARCH) && (hist_d != PREAMBLE)
                    && (search_cnt_q == SC_W'(SEARCH_TO - 1));
  assign push     = dec_v_q && (state_q == PAYLOAD);
  assign pop      = sym_ready && !fifo_empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      phase_q     <= '0;
      slip_q      <= 1'b0;
      dec_v_q     <= 1'b0;
      dec_dibit_q <= 2'b00;
    end else begin
      dec_v_q <= 1'b0;
      if (in_valid) begin
        if (slip_q) begin
          slip_q <= 1'b0;
        end else if (phase_q == PH_W'(SPS - 1)) begin
          acc_i_q     <= '0;
          acc_q_q     <= '0;
          phase_q     <= '0;
          dec_v_q     <= 1'b1;
          dec_dibit_q <= {sum_i_d[ACC_W-1] ? QPSK_NEG_BIT : QPSK_POS_BIT,
                          sum_q_d[ACC_W-1] ? QPSK_NEG_BIT : QPSK_POS_BIT};
        end else begin
          acc_i_q <= sum_i_d;
          acc_q_q <= sum_q_d;
          phase_q <= phase_q + PH_W'(1);
        end
      end
      if (slip_set) begin
        slip_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= SEARCH;
      hist_q       <= '0;
      search_cnt_q <= '0;
      pay_cnt_q    <= '0;
      overflow_q   <= 1'b0;
    end else begin
      if (push && fifo_full && !pop) begin
        overflow_q <= 1'b1;
      end
      if (dec_v_q) begin
        case (state_q)
          SEARCH: begin
            hist_q <= hist_d[HIST_W-3:0];
            if (hist_d == PREAMBLE) begin
              state_q      <= PAYLOAD;
              pay_cnt_q    <= '0;
              search_cnt_q <= '0;
            end else if (search_cnt_q == SC_W'(SEARCH_TO - 1)) begin
              search_cnt_q <= '0;
            end else begin
              search_cnt_q <= search_cnt_q + SC_W'(1);
            end
          end
          PAYLOAD: begin
            if (pay_last) begin
              state_q <= SEARCH;
              hist_q  <= '0;
            end else begin
              pay_cnt_q <= pay_cnt_q + PC_W'(1);
            end
          end
        endcase
      end
    end
  end

  qpsk_symbol_fifo u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i ({dec_dibit_q, pay_last}),
    .pop_i       (pop),
    .pop_data_o  (fifo_dout),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign sym_valid = !fifo_empty;
  assign sym_data  = fifo_dout[2:1];
  assign sym_last  = fifo_dout[0];
  assign locked    = (state_q == PAYLOAD);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_qpsk_demodulator.sv
// Self-checking bench for qpsk_demodulator: random payloads are modulated into
// I/Q samples and the delivered dibits are compared against the transmitted ones.
module tb_qpsk_demodulator;

  localparam int          SPS          = 4;
  localparam int          PRE_SYMS     = 8;
  localparam int          PAYLOAD_SYMS = 64;
  localparam logic [15:0] PRE_WORD     = 16'hE4E4;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [15:0] i_in = '0;
  logic signed [15:0] q_in = '0;
  logic               sym_valid;
  logic               sym_ready = 1'b0;
  logic [1:0]         sym_data;
  logic               sym_last;
  logic               locked;
  logic               overflow;

  qpsk_demodulator dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .i_in      (i_in),
    .q_in      (q_in),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .sym_data  (sym_data),
    .sym_last  (sym_last),
    .locked    (locked),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0] d;
    logic       last;
  } exp_t;

  exp_t       expQ[$];
  logic [1:0] payload[PAYLOAD_SYMS];
  logic [1:0] pay1[PAYLOAD_SYMS];
  bit         zeroI[PAYLOAD_SYMS];
  int         errors = 0;
  int         checks = 0;
  int         payload0Cyc = 0;
  int         firstValidCyc = -1;
  int         lockRises = 0;
  logic       lockedPrev = 1'b0;
  logic       lockedAt10 = 1'b0;

  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Output monitor: every presented dibit must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset) begin
      if (locked && !lockedPrev) lockRises++;
      lockedPrev = locked;
      if (sym_valid) begin
        if (firstValidCyc < 0) firstValidCyc = cyc;
        if (expQ.size() == 0) begin
          checkOutput("unexpected_valid", 1, 0);
        end else begin
          checkOutput("sym_data", sym_data, expQ[0].d);
          checkOutput("sym_last", sym_last, expQ[0].last);
          if (sym_ready) void'(expQ.pop_front());
        end
      end
    end else begin
      lockedPrev = 1'b0;
    end
  end

  task automatic applyStimulus(input int iv, input int qv, input int gapPct, output int capCyc);
    for (int g = 0; g < 16; g++) begin
      if (int'($urandom_range(99)) >= gapPct) break;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    i_in     = 16'(iv);
    q_in     = 16'(qv);
    @(posedge clk);
    #1;
    capCyc   = cyc;
    in_valid = 1'b0;
  endtask

  function automatic int amp(input int noise);
    if (noise == 0) return 1000;
    return 1000 + int'($urandom_range(2 * noise)) - noise;
  endfunction

  // Modulator model: 00->(+,+) 01->(+,-) 10->(-,+) 11->(-,-); zi forces a zero-sum I channel.
  task automatic sendSymbol(input logic [1:0] d, input int noise, input bit zi,
                            input int gapPct, output int lastCyc);
    int ai[SPS];
    int iv, qv, c;
    for (int k = 0; k < SPS; k++) ai[k] = amp(noise);
    for (int k = 0; k < SPS; k++) begin
      if (zi) iv = (k % 2 == 0) ? ai[k] : -ai[k-1];
      else    iv = d[1] ? -ai[k] : ai[k];
      qv = d[0] ? -amp(noise) : amp(noise);
      applyStimulus(iv, qv, gapPct, c);
    end
    lastCyc = c;
  endtask

  task automatic sendFrame(input int noise, input int gapPct, input int nPay);
    logic [15:0] pre;
    logic [1:0]  pd;
    int          c;
    pre = PRE_WORD;
    for (int p = 0; p < PRE_SYMS; p++) begin
      pd = pre[15 - 2*p -: 2];
      sendSymbol(pd, noise, 1'b0, gapPct, c);
    end
    for (int j = 0; j < nPay; j++) begin
      if (j == 10) lockedAt10 = locked;
      sendSymbol(payload[j], noise, zeroI[j], gapPct, c);
      if (j == 0) payload0Cyc = c;
    end
    if (nPay == PAYLOAD_SYMS) begin
      for (int p = 0; p < 2; p++) sendSymbol(2'b00, 0, 1'b0, gapPct, c);
    end
  endtask

  task automatic newPayload(input int zeroCount);
    for (int j = 0; j < PAYLOAD_SYMS; j++) begin
      payload[j] = 2'($urandom_range(3));
      zeroI[j]   = 1'b0;
    end
    for (int z = 0; z < zeroCount; z++) zeroI[$urandom_range(PAYLOAD_SYMS - 1)] = 1'b1;
  endtask

  task automatic fillExpected(input int count);
    exp_t e;
    expQ.delete();
    for (int j = 0; j < count; j++) begin
      e.d    = zeroI[j] ? {1'b0, payload[j][0]} : payload[j];
      e.last = (j == PAYLOAD_SYMS - 1);
      expQ.push_back(e);
    end
  endtask

  task automatic waitDrain(input string tag);
    for (int k = 0; k < 64 && expQ.size() > 0; k++) @(posedge clk);
    #1;
    checkOutput({tag, "_drain"}, expQ.size(), 0);
  endtask

  task automatic doReset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int c;
    doReset();
    @(negedge clk);
    checkOutput("rst_sym_valid", sym_valid, 0);
    checkOutput("rst_locked", locked, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_sym_data", sym_data, 0);
    checkOutput("rst_sym_last", sym_last, 0);
    @(posedge clk);
    #1;

    $display("[TB] scenario 1: clean frame, ready high");
    sym_ready = 1'b1;
    newPayload(0);
    pay1 = payload;
    fillExpected(PAYLOAD_SYMS);
    firstValidCyc = -1;
    lockRises = 0;
    sendFrame(0, 0, PAYLOAD_SYMS);
    waitDrain("s1");
    checkOutput("s1_latency", firstValidCyc - payload0Cyc, 1);
    checkOutput("s1_lock_rises", lockRises, 1);
    checkOutput("s1_locked_mid", lockedAt10, 1);
    checkOutput("s1_locked_end", locked, 0);
    checkOutput("s1_overflow", overflow, 0);

    $display("[TB] scenario 2: noisy samples and zero-sum symbols");
    doReset();
    newPayload(6);
    fillExpected(PAYLOAD_SYMS);
    sendFrame(600, 0, PAYLOAD_SYMS);
    waitDrain("s2");
    checkOutput("s2_overflow", overflow, 0);

    $display("[TB] scenario 3: stream offset by two samples");
    doReset();
    newPayload(0);
    fillExpected(PAYLOAD_SYMS);
    lockRises = 0;
    for (int k = 0; k < 2; k++) applyStimulus(1000, 1000, 0, c);
    for (int s = 0; s < 40; s++) sendSymbol(2'b00, 0, 1'b0, 0, c);
    sendFrame(0, 0, PAYLOAD_SYMS);
    waitDrain("s3");
    checkOutput("s3_lock_rises", lockRises, 1);

    $display("[TB] scenario 4: consumer stalled for whole payload");
    doReset();
    sym_ready = 1'b0;
    newPayload(0);
    fillExpected(2);
    sendFrame(0, 0, PAYLOAD_SYMS);
    checkOutput("s4_locked_mid", lockedAt10, 1);
    checkOutput("s4_locked_end", locked, 0);
    checkOutput("s4_overflow", overflow, 1);
    checkOutput("s4_held_valid", sym_valid, 1);
    sym_ready = 1'b1;
    waitDrain("s4");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("s4_empty_after", sym_valid, 0);

    $display("[TB] scenario 5: random input gaps");
    doReset();
    payload = pay1;
    for (int j = 0; j < PAYLOAD_SYMS; j++) zeroI[j] = 1'b0;
    fillExpected(PAYLOAD_SYMS);
    lockRises = 0;
    sendFrame(0, 50, PAYLOAD_SYMS);
    waitDrain("s5");
    checkOutput("s5_lock_rises", lockRises, 1);

    $display("[TB] scenario 6: reset in the middle of a payload");
    doReset();
    sym_ready = 1'b0;
    newPayload(0);
    fillExpected(2);
    sendFrame(0, 0, 30);
    checkOutput("s6_pre_overflow", overflow, 1);
    checkOutput("s6_pre_locked", locked, 1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    checkOutput("s6_rst_valid", sym_valid, 0);
    checkOutput("s6_rst_locked", locked, 0);
    checkOutput("s6_rst_overflow", overflow, 0);
    expQ.delete();
    sym_ready = 1'b1;
    newPayload(0);
    fillExpected(PAYLOAD_SYMS);
    lockRises = 0;
    sendFrame(0, 0, PAYLOAD_SYMS);
    waitDrain("s6");
    checkOutput("s6_lock_rises", lockRises, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule
